seq_piso_8b_tx: RTL and testbench
=================================

Name: seq_piso_8b_tx

Overview:
- Byte-to-serial transmitter that sits directly upstream of the 8-bit SIPO shift register and drives its en/sin inputs.
- Accepts bytes over a valid/ready interface into a 2-entry buffer.
- Shifts each byte out MSB-first, one bit per enabled cycle, so the downstream SIPO holds the original byte after 8 enabled edges.
- Back-to-back bytes stream with no idle gap.

Parameters:
- NBITS, 8, frame width in bits. Fixed at 8 for this block; the counter is sized as clog2(NBITS).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_val  input  1  upstream byte valid
- in_rdy  output  1  block can accept a byte this cycle
- in_data  input  8  byte to transmit
- out_en  output  1  serial bit valid; connects to the SIPO en
- out_sin  output  1  serial data bit; connects to the SIPO sin
- frame_last  output  1  high while the last (LSB) bit of a frame is on out_sin
- busy  output  1  high when the shifter is active or the buffer is non-empty

Behaviour:
- Reset (clk is the clock; reset is synchronous, active-high):
  - state=IDLE, buffer count=0, shift reg=0, bit counter=0.
  - While reset is high: out_en=0, out_sin=0, frame_last=0, busy=0, in_rdy=0.
  - Reset mid-frame aborts the frame and discards all buffered bytes; nothing partial is emitted afterwards.
- Input buffer:
  - 2-entry FIFO.
  - in_rdy = !reset && (count != 2). in_rdy depends only on registered count, never on same-cycle pop.
  - Push occurs on an edge where in_val && in_rdy.
  - in_data is ignored when not accepted. No duplicate accept while in_val is held across a stall.
  - Push and pop on the same edge: count is unchanged; entry order is preserved.
- Shifter FSM, states IDLE and SHIFT:
  - IDLE: out_en=0, out_sin=0. If count>0 at an edge: pop head into shreg, cnt<=0, go to SHIFT. If count==0, stay in IDLE.
  - SHIFT: out_en=1, out_sin=shreg[7]. At each edge: shreg<=shreg<<1, cnt<=cnt+1.
  - When cnt==7: frame_last=1. At that edge, if count>0 (evaluated before any same-edge push), pop the next byte into shreg, cnt<=0, and stay in SHIFT; otherwise go to IDLE.
  - A byte pushed on the same edge as cnt==7 into an empty buffer is not popped until the following edge. That produces a single idle cycle.
- out_sin is forced to 0 whenever out_en=0.
- Latency: byte accepted at end of cycle 0 into an idle, empty block:
  - cycle 1: load
  - cycles 2..9: bits 7..0 on out_sin with out_en=1
  - frame_last high in cycle 9
  - downstream SIPO pout equals the byte after the edge ending cycle 9
- Throughput: 8 cycles per byte sustained while the buffer stays non-empty.
- busy = (state==SHIFT) || (count!=0).

Test Plan:
- Assert reset 2 cycles, then release -> during reset in_rdy=0 and out_en=0; first cycle after reset in_rdy=1, busy=0, out_sin=0.
- Single byte 0xA5 accepted in cycle 0 -> out_en=1 for cycles 2..9 only; out_sin=1,0,1,0,0,1,0,1; frame_last only in cycle 9; attached SIPO pout=0xA5 after cycle 9.
- in_val held with 0x3C, 0xFF, 0x01 back-to-back -> in_rdy drops once 2 bytes are buffered; 24 consecutive out_en cycles with no gap; serial stream 00111100 11111111 00000001; frame_last every 8th cycle.
- Stall: present a 4th byte 0x77 while the buffer is full, holding in_val -> not accepted until in_rdy=1; accepted exactly once; transmitted after the prior bytes.
- Reset asserted after 4 bits of 0xF0 with 0x12 buffered -> out_en=0 next cycle, busy=0; 0x12 is never emitted; a subsequent 0x81 transmits cleanly as 10000001.
- Push 0x55 on the same edge as frame_last of the final byte with an empty buffer -> exactly one out_en=0 cycle, then 01010101.

Source files
------------

// File: rtl/seq_piso_8b_tx.sv
// seq_piso_8b_tx
// Byte-to-serial transmitter feeding an 8-bit SIPO (out_en -> en, out_sin -> sin).
// Bytes arrive over valid/ready into a 2-entry FIFO. Each byte is shifted out
// MSB-first, one bit per cycle. Back-to-back bytes stream with no idle gap
// whenever the next byte is already buffered when the last bit goes out.

module seq_piso_8b_tx #(
   parameter int NBITS = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_val,
   output logic             in_rdy,
   input  logic [NBITS-1:0] in_data,
   output logic             out_en,
   output logic             out_sin,
   output logic             frame_last,
   output logic             busy
);

   localparam int CW    = $clog2(NBITS);
   localparam int DEPTH = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------
   state_t           state_reg, state_next;
   logic [NBITS-1:0] shreg_reg, shreg_next;
   logic [CW-1:0]    cnt_reg,   cnt_next;

   logic [NBITS-1:0] fifo_mem [DEPTH];
   logic [DEPTH-1:0] entry_we;
   logic             wr_ptr_reg, wr_ptr_next;
   logic             rd_ptr_reg, rd_ptr_next;
   logic [1:0]       count_reg,  count_next;

   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic             last_bit;
   logic [NBITS-1:0] fifo_head;

   // ------------------------------------------------------------------
   // Buffer status and handshake
   // ------------------------------------------------------------------
   // Ready looks only at the registered count, so a pop on the same edge
   // never opens an extra slot combinationally.
   assign fifo_full  = (count_reg == 2'(DEPTH));
   assign fifo_empty = (count_reg == 2'd0);
   assign in_rdy     = !reset && !fifo_full;
   assign push       = in_val && in_rdy;

   // The final bit of the current frame is on the line.
   assign last_bit   = (state_reg == SHIFT) && (cnt_reg == CW'(NBITS - 1));

   // Pop whenever the shifter can take a new byte. The count used here is
   // the pre-edge value, so a byte pushed on this edge is not visible yet.
   assign pop        = !fifo_empty && ((state_reg == IDLE) || last_bit);

   assign fifo_head  = fifo_mem[rd_ptr_reg];

   // ------------------------------------------------------------------
   // Per-entry write enables
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry_we
         assign entry_we[gi] = push && (wr_ptr_reg == 1'(gi));
      end
   endgenerate

   // Store accepted bytes into the slot addressed by the write pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (entry_we[i]) begin
               fifo_mem[i] <= in_data;
            end
         end
      end
   end

   // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged.
   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (push) begin
         wr_ptr_next = wr_ptr_reg + 1'b1;
      end
      if (pop) begin
         rd_ptr_next = rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_next = count_reg + 2'd1;
         2'b01:   count_next = count_reg - 2'd1;
         default: count_next = count_reg;
      endcase
   end

   // Register the FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   // ------------------------------------------------------------------
   // Shifter FSM
   // ------------------------------------------------------------------
   // State, shift register and bit counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         shreg_reg <= '0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         shreg_reg <= shreg_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Next-state logic: load from the FIFO head, shift MSB-first, chain frames.
   always_comb begin
      state_next = state_reg;
      shreg_next = shreg_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (pop) begin
               shreg_next = fifo_head;
               cnt_next   = '0;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            shreg_next = shreg_reg << 1;
            cnt_next   = cnt_reg + 1'b1;
            if (last_bit) begin
               cnt_next = '0;
               if (pop) begin
                  // Next byte already waiting: start it with no gap.
                  shreg_next = fifo_head;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: begin
            state_next = IDLE;
            shreg_next = '0;
            cnt_next   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs; all held low while reset is asserted.
   // ------------------------------------------------------------------
   assign out_en     = !reset && (state_reg == SHIFT);
   assign out_sin    = out_en && shreg_reg[NBITS-1];
   assign frame_last = !reset && last_bit;
   assign busy       = !reset && ((state_reg == SHIFT) || !fifo_empty);

endmodule

// File: tb/tb_seq_piso_8b_tx.sv
// tb_seq_piso_8b_tx
// Directed bench for seq_piso_8b_tx. Cycle-by-cycle vector tables cover reset,
// a single frame, reset mid-frame and the one-cycle gap case; a hand-written
// sequence covers back-to-back streaming with a stalled fourth byte.
// A small SIPO model collects the serial stream like the real downstream block.

module tb_seq_piso_8b_tx;

   logic       clk;
   logic       reset;
   logic       in_val;
   logic       in_rdy;
   logic [7:0] in_data;
   logic       out_en;
   logic       out_sin;
   logic       frame_last;
   logic       busy;

   int n_checks;
   int n_fail;

   logic [7:0] sipo_pout;

   typedef struct {
      logic       rst;
      logic       val;
      logic [7:0] data;
      logic       rdy;
      logic       en;
      logic       sin;
      logic       fl;
      logic       busy;
   } vec_t;

   vec_t vec[$];

   seq_piso_8b_tx #(.NBITS(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_val     (in_val),
      .in_rdy     (in_rdy),
      .in_data    (in_data),
      .out_en     (out_en),
      .out_sin    (out_sin),
      .frame_last (frame_last),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream SIPO model: shifts sin in at the LSB on each enabled edge.
   always @(posedge clk) begin
      if (out_en) sipo_pout <= {sipo_pout[6:0], out_sin};
   end

   task automatic chk(input string name, input int cyc, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic add(input logic rst, input logic val, input logic [7:0] data,
                      input logic rdy, input logic en, input logic sin,
                      input logic fl, input logic bsy);
      vec_t v;
      v.rst = rst; v.val = val; v.data = data;
      v.rdy = rdy; v.en = en; v.sin = sin; v.fl = fl; v.busy = bsy;
      vec.push_back(v);
   endtask

   task automatic run_table(input string tag);
      for (int i = 0; i < vec.size(); i++) begin
         @(negedge clk);
         reset   = vec[i].rst;
         in_val  = vec[i].val;
         in_data = vec[i].data;
         #1;
         chk({tag, ".in_rdy"},     i, {7'd0, in_rdy},     {7'd0, vec[i].rdy});
         chk({tag, ".out_en"},     i, {7'd0, out_en},     {7'd0, vec[i].en});
         chk({tag, ".out_sin"},    i, {7'd0, out_sin},    {7'd0, vec[i].sin});
         chk({tag, ".frame_last"}, i, {7'd0, frame_last}, {7'd0, vec[i].fl});
         chk({tag, ".busy"},       i, {7'd0, busy},       {7'd0, vec[i].busy});
         $display("%s row %0d: rst=%b val=%b data=%h -> rdy=%b en=%b sin=%b fl=%b busy=%b",
                  tag, i, reset, in_val, in_data, in_rdy, out_en, out_sin, frame_last, busy);
      end
   endtask

   initial begin
      logic [7:0] src [4];
      int         idx;
      int         acc77;
      int         k;
      logic       e_rdy, e_en, e_sin, e_fl, e_busy;

      n_checks  = 0;
      n_fail    = 0;
      sipo_pout = 8'h00;
      reset     = 1'b1;
      in_val    = 1'b0;
      in_data   = 8'h00;

      // ---------------- Table 1: reset, then single byte 0xA5 ----------------
      add(1, 0, 8'h00, 0, 0, 0, 0, 0);   // reset cycle
      add(1, 0, 8'h00, 0, 0, 0, 0, 0);   // reset cycle
      add(0, 0, 8'h00, 1, 0, 0, 0, 0);   // first cycle after reset
      add(0, 1, 8'hA5, 1, 0, 0, 0, 0);   // c0: accept A5
      add(0, 0, 8'h00, 1, 0, 0, 0, 1);   // c1: load
      add(0, 0, 8'h00, 1, 1, 1, 0, 1);   // c2: bit7
      add(0, 0, 8'h00, 1, 1, 0, 0, 1);   // c3
      add(0, 0, 8'h00, 1, 1, 1, 0, 1);   // c4
      add(0, 0, 8'h00, 1, 1, 0, 0, 1);   // c5
      add(0, 0, 8'h00, 1, 1, 0, 0, 1);   // c6
      add(0, 0, 8'h00, 1, 1, 1, 0, 1);   // c7
      add(0, 0, 8'h00, 1, 1, 0, 0, 1);   // c8
      add(0, 0, 8'h00, 1, 1, 1, 1, 1);   // c9: bit0, frame_last
      add(0, 0, 8'h00, 1, 0, 0, 0, 0);   // c10: idle
      run_table("single");
      chk("single.sipo", 10, sipo_pout, 8'hA5);
      vec.delete();

      // ---------------- Stream: 3C FF 01 then stalled 77 ----------------
      src[0] = 8'h3C; src[1] = 8'hFF; src[2] = 8'h01; src[3] = 8'h77;
      idx   = 0;
      acc77 = 0;
      for (int c = 0; c <= 34; c++) begin
         @(negedge clk);
         reset = 1'b0;
         if (idx < 4) begin
            in_val  = 1'b1;
            in_data = src[idx];
         end else begin
            in_val  = 1'b0;
            in_data = 8'h00;
         end
         #1;
         e_rdy  = (c <= 2) || (c == 10) || (c >= 18);
         e_en   = (c >= 2) && (c <= 33);
         k      = c - 2;
         e_sin  = e_en ? src[k / 8][7 - (k % 8)] : 1'b0;
         e_fl   = e_en && ((k % 8) == 7);
         e_busy = (c >= 1) && (c <= 33);
         chk("stream.in_rdy",     c, {7'd0, in_rdy},     {7'd0, e_rdy});
         chk("stream.out_en",     c, {7'd0, out_en},     {7'd0, e_en});
         chk("stream.out_sin",    c, {7'd0, out_sin},    {7'd0, e_sin});
         chk("stream.frame_last", c, {7'd0, frame_last}, {7'd0, e_fl});
         chk("stream.busy",       c, {7'd0, busy},       {7'd0, e_busy});
         $display("stream cycle %0d: val=%b data=%h -> rdy=%b en=%b sin=%b fl=%b busy=%b",
                  c, in_val, in_data, in_rdy, out_en, out_sin, frame_last, busy);
         if (in_val && in_rdy) begin
            if (idx == 3) acc77++;
            idx++;
         end
      end
      chk("stream.accepted", 34, 8'(idx), 8'd4);
      chk("stream.acc77",    34, 8'(acc77), 8'd1);
      chk("stream.sipo",     34, sipo_pout, 8'h77);

      // ---------------- Table 2: reset mid-frame, then same-edge push gap ----------------
      add(0, 1, 8'hF0, 1, 0, 0, 0, 0);   // c0: accept F0
      add(0, 1, 8'h12, 1, 0, 0, 0, 1);   // c1: load F0, accept 12
      add(0, 0, 8'h00, 1, 1, 1, 0, 1);   // c2..c5: F0 bits 7..4
      add(0, 0, 8'h00, 1, 1, 1, 0, 1);
      add(0, 0, 8'h00, 1, 1, 1, 0, 1);
      add(0, 0, 8'h00, 1, 1, 1, 0, 1);
      add(1, 0, 8'h00, 0, 0, 0, 0, 0);   // c6: reset
      add(0, 0, 8'h00, 1, 0, 0, 0, 0);   // c7: empty, 0x12 gone
      add(0, 1, 8'h81, 1, 0, 0, 0, 0);   // c8: accept 81
      add(0, 0, 8'h00, 1, 0, 0, 0, 1);   // c9: load
      add(0, 0, 8'h00, 1, 1, 1, 0, 1);   // c10..c17: 10000001
      add(0, 0, 8'h00, 1, 1, 0, 0, 1);
      add(0, 0, 8'h00, 1, 1, 0, 0, 1);
      add(0, 0, 8'h00, 1, 1, 0, 0, 1);
      add(0, 0, 8'h00, 1, 1, 0, 0, 1);
      add(0, 0, 8'h00, 1, 1, 0, 0, 1);
      add(0, 0, 8'h00, 1, 1, 0, 0, 1);
      add(0, 1, 8'h55, 1, 1, 1, 1, 1);   // c17: last bit, push 55 same edge
      add(0, 0, 8'h00, 1, 0, 0, 0, 1);   // c18: the single idle cycle
      add(0, 0, 8'h00, 1, 1, 0, 0, 1);   // c19..c26: 01010101
      add(0, 0, 8'h00, 1, 1, 1, 0, 1);
      add(0, 0, 8'h00, 1, 1, 0, 0, 1);
      add(0, 0, 8'h00, 1, 1, 1, 0, 1);
      add(0, 0, 8'h00, 1, 1, 0, 0, 1);
      add(0, 0, 8'h00, 1, 1, 1, 0, 1);
      add(0, 0, 8'h00, 1, 1, 0, 0, 1);
      add(0, 0, 8'h00, 1, 1, 1, 1, 1);
      add(0, 0, 8'h00, 1, 0, 0, 0, 0);   // c27: idle
      run_table("reset_gap");
      chk("reset_gap.sipo", 27, sipo_pout, 8'h55);
      vec.delete();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
